// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD adder slice.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_serial_adder_ctrl_if.sv
// Request/result bundle between an operand source and the serial BCD adder.
interface bcd_serial_adder_ctrl_if #(
  parameter int N_DIGITS = 4
);
  logic                  start;
  logic [4*N_DIGITS-1:0] a;
  logic [4*N_DIGITS-1:0] b;
  logic                  cin;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic [4*N_DIGITS-1:0] sum;
  logic                  cout;
  logic                  err;

  modport master (
    output start, a, b, cin,
    input  ready, busy, done, sum, cout, err
  );

  modport slave (
    input  start, a, b, cin,
    output ready, busy, done, sum, cout, err
  );
endinterface

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder; invalid digits (>9) use the same >9 correction rule.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       ci,
  output bcd_digit_t s,
  output logic       co,
  output logic       invalid
);

  logic [4:0] t;
  logic [4:0] t_adj;

  always_comb begin
    t       = {1'b0, a} + {1'b0, b} + {4'b0, ci};
    t_adj   = t - 5'd10;
    s       = t[3:0];
    co      = 1'b0;
    if (t > {1'b0, BCD_MAX}) begin
      s  = t_adj[3:0];
      co = 1'b1;
    end
    invalid = (a > BCD_MAX) || (b > BCD_MAX);
  end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Sequences one BCD digit adder over N_DIGITS digits, LSD first, one digit per clock.
module bcd_serial_adder_ctrl
  import bcd_pkg::*;
#(
  parameter int N_DIGITS = 4
) (
  input logic                      clk,
  input logic                      reset,
  bcd_serial_adder_ctrl_if.slave   bus
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  state_t                state;
  logic [IDX_W-1:0]      idx;
  logic [4*N_DIGITS-1:0] opa;
  logic [4*N_DIGITS-1:0] opb;
  logic                  carry;
  logic [4*N_DIGITS-1:0] sum_r;
  logic                  cout_r;
  logic                  err_r;
  logic                  ready_r;
  logic                  busy_r;
  logic                  done_r;

  bcd_digit_t cur_a;
  bcd_digit_t cur_b;
  bcd_digit_t dig_s;
  logic       dig_co;
  logic       dig_inv;

  always_comb begin
    cur_a = opa[4*idx +: 4];
    cur_b = opb[4*idx +: 4];
  end

  bcd_digit_add u_digit (
    .a       (cur_a),
    .b       (cur_b),
    .ci      (carry),
    .s       (dig_s),
    .co      (dig_co),
    .invalid (dig_inv)
  );

  // Status flags are registered alongside the state so they change on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      opa     <= '0;
      opb     <= '0;
      carry   <= 1'b0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      err_r   <= 1'b0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            opa     <= bus.a;
            opb     <= bus.b;
            carry   <= bus.cin;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            err_r   <= 1'b0;
            idx     <= '0;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          sum_r[4*idx +: 4] <= dig_s;
          carry             <= dig_co;
          err_r             <= err_r | dig_inv;
          if (idx == LAST_IDX) begin
            cout_r <= dig_co;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready = ready_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.sum   = sum_r;
  assign bus.cout  = cout_r;
  assign bus.err   = err_r;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Self-checking bench: cycle-level reference model plus directed literal cases and random traffic.
module tb_bcd_serial_adder_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic clk;
  logic reset;

  int checks;
  int errors;
  bit chk_en;

  bcd_serial_adder_ctrl_if #(.N_DIGITS(N)) bus ();

  bcd_serial_adder_ctrl #(.N_DIGITS(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: digit-wise addition of the lowest ndig digits by the decimal rule.
  function automatic void ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic c, input int ndig,
                                  output logic [W-1:0] s, output logic co, output logic e);
    int da, db, t, cc;
    s  = '0;
    e  = 1'b0;
    cc = int'(c);
    for (int i = 0; i < ndig; i++) begin
      da = int'((a >> (4 * i)) & W'(15));
      db = int'((b >> (4 * i)) & W'(15));
      t  = da + db + cc;
      if (t > 9) begin
        t  = (t - 10) % 16;
        cc = 1;
      end else begin
        cc = 0;
      end
      s = s | (W'(t) << (4 * i));
      if (da > 9 || db > 9) e = 1'b1;
    end
    co = (cc != 0);
  endfunction

  // Model state: phase 0 idle, 1..N running, N+1 done pulse; cnt = digits committed.
  int           m_phase;
  int           m_cnt;
  logic [W-1:0] m_a, m_b;
  logic         m_cin;

  always @(posedge clk) begin
    if (reset) begin
      m_phase <= 0;
      m_cnt   <= 0;
      m_a     <= '0;
      m_b     <= '0;
      m_cin   <= 1'b0;
    end else if (m_phase == 0) begin
      if (bus.start) begin
        m_a     <= bus.a;
        m_b     <= bus.b;
        m_cin   <= bus.cin;
        m_phase <= 1;
        m_cnt   <= 0;
      end
    end else if (m_phase <= N) begin
      m_phase <= m_phase + 1;
      m_cnt   <= m_cnt + 1;
    end else begin
      m_phase <= 0;
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    logic [W-1:0] es;
    logic         eco, ee;
    ref_add(m_a, m_b, m_cin, m_cnt, es, eco, ee);
    check("ready", W'(bus.ready), W'(m_phase == 0));
    check("busy",  W'(bus.busy),  W'(m_phase >= 1 && m_phase <= N));
    check("done",  W'(bus.done),  W'(m_phase == N + 1));
    check("sum",   bus.sum, es);
    check("cout",  W'(bus.cout), W'((m_cnt == N) ? eco : 1'b0));
    check("err",   W'(bus.err),  W'(ee));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic [W-1:0] es, input logic eco, input logic ee);
    int n;
    check({name, "_ready"}, W'(bus.ready), W'(1));
    bus.a     = a;
    bus.b     = b;
    bus.cin   = c;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 50) begin
      tick();
      n++;
    end
    check({name, "_latency"}, W'(n), W'(N));
    check({name, "_sum"},  bus.sum, es);
    check({name, "_cout"}, W'(bus.cout), W'(eco));
    check({name, "_err"},  W'(bus.err),  W'(ee));
    tick();
  endtask

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 7) == 0) v = v | (W'($urandom_range(0, 15)) << (4 * i));
      else v = v | (W'($urandom_range(0, 9)) << (4 * i));
    end
    return v;
  endfunction

  initial begin
    int dcount;
    logic [W-1:0] dsum;
    checks    = 0;
    errors    = 0;
    chk_en    = 1'b0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (chk_en) compare_cycle();
      end
    join_none

    tick();
    tick();
    check("rst_ready", W'(bus.ready), W'(1));
    check("rst_busy",  W'(bus.busy),  W'(0));
    check("rst_done",  W'(bus.done),  W'(0));
    check("rst_sum",   bus.sum, '0);
    reset  = 1'b0;
    chk_en = 1'b1;
    tick();

    run_op("basic",   16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
    run_op("ripple",  16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("cin",     16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
    run_op("max",     16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);
    run_op("invalid", 16'h000A, 16'h0000, 1'b0, 16'h0010, 1'b0, 1'b1);
    run_op("errclr",  16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    run_op("allf",    16'hFFFF, 16'hFFFF, 1'b1, 16'h5555, 1'b1, 1'b1);

    // start re-pulsed and operands changed while running must be ignored
    bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0; bus.start = 1'b1;
    tick();
    dcount = 0;
    dsum   = '0;
    for (int i = 0; i < N + 3; i++) begin
      if (i < 2) begin
        bus.start = 1'b1;
        bus.a     = 16'h9999;
        bus.b     = 16'h9999;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      if (bus.done) begin
        dcount++;
        dsum = bus.sum;
      end
    end
    check("ignore_dones", W'(dcount), W'(1));
    check("ignore_sum",   dsum, 16'h3333);

    // reset after two digits committed
    bus.a = 16'h1234; bus.b = 16'h5678; bus.cin = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_ready", W'(bus.ready), W'(1));
    check("midrst_busy",  W'(bus.busy),  W'(0));
    check("midrst_sum",   bus.sum, '0);
    check("midrst_cout",  W'(bus.cout), W'(0));
    check("midrst_err",   W'(bus.err),  W'(0));
    dcount = 0;
    for (int i = 0; i < N + 2; i++) begin
      if (bus.done) dcount++;
      tick();
    end
    check("midrst_nodone", W'(dcount), W'(0));
    run_op("after_rst", 16'h0450, 16'h0550, 1'b0, 16'h1000, 1'b0, 1'b0);

    // random traffic: start during busy, operand churn, occasional reset
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset     = ($urandom_range(0, 79) == 0);
      bus.start = ($urandom_range(0, 2) == 0);
      bus.a     = rand_operand();
      bus.b     = rand_operand();
      bus.cin   = 1'($urandom_range(0, 1));
      tick();
    end
    reset     = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < N + 3; i++) tick();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
